// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell plus a borrow flop
// computes A - B over WIDTH clocks behind a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_d,
    output logic             o_d_valid,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_done
);

    // state | meaning
    // IDLE  | waiting for i_start, last result held on o_diff/o_borrow
    // SHIFT | one difference bit per cycle, LSB first
    // DONE  | one-cycle o_done pulse with the new result
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             bf;
    logic [CW-1:0]    cnt;

    logic bit_a;
    logic bit_b;
    logic hs1_d;
    logic hs1_b;
    logic hs2_b;
    logic d;
    logic bout;
    logic last_bit;

    // Full subtractor built from two half subtractors.
    assign bit_a    = sa[0];
    assign bit_b    = sb[0];
    assign hs1_d    = bit_a ^ bit_b;
    assign hs1_b    = ~bit_a & bit_b;
    assign d        = hs1_d ^ bf;
    assign hs2_b    = ~hs1_d & bf;
    assign bout     = hs1_b | hs2_b;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bf       <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        sa    <= i_a;
                        sb    <= i_b;
                        bf    <= 1'b0;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bf  <= bout;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= {d, res[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        // Published copy is separate so o_diff holds steady during SHIFT.
                        diff_q   <= {d, res[WIDTH-1:1]};
                        borrow_q <= bout;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy    = (state != S_IDLE);
    assign o_d_valid = (state == S_SHIFT);
    assign o_d       = o_d_valid & d;
    assign o_done    = (state == S_DONE);
    assign o_diff    = diff_q;
    assign o_borrow  = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle-level reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_busy;
    logic         o_d;
    logic         o_d_valid;
    logic [W-1:0] o_diff;
    logic         o_borrow;
    logic         o_done;

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (o_busy),
        .o_d      (o_d),
        .o_d_valid(o_d_valid),
        .o_diff   (o_diff),
        .o_borrow (o_borrow),
        .o_done   (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: k = cycles since the accepted start (0 = idle).
    int           k;
    logic [W-1:0] m_diff;
    logic         m_borrow;
    logic [W-1:0] last_diff;
    logic         last_borrow;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            k           = 0;
            m_diff      = '0;
            m_borrow    = 1'b0;
            last_diff   = '0;
            last_borrow = 1'b0;
        end else if (k == 0) begin
            if (i_start) begin
                m_diff   = W'(int'(i_a) - int'(i_b));
                m_borrow = (i_a < i_b);
                k        = 1;
            end
        end else if (k == W + 1) begin
            k = 0;
        end else begin
            k = k + 1;
            if (k == W + 1) begin
                last_diff   = m_diff;
                last_borrow = m_borrow;
            end
        end
    end

    always @(posedge i_clk) begin
        logic [12:0] act;
        logic [12:0] exp;
        logic        e_shift;
        #1;
        e_shift = (k >= 1) && (k <= W);
        exp = {(k >= 1), e_shift, e_shift ? m_diff[(k > 0 ? k - 1 : 0)] : 1'b0,
               (k == W + 1), last_borrow, last_diff};
        act = {o_busy, o_d_valid, o_d, o_done, o_borrow, o_diff};
        check("cycle", 32'(act), 32'(exp));
    end

    // Directed op: optional ignored-start injection or mid-op reset at SHIFT step index.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_diff, input logic exp_borrow,
                          input int inj_at, input int rst_at, input string tag);
        logic [W-1:0] seq;
        int idx;
        int lat;
        bit got;
        seq = '0;
        idx = 0;
        lat = -1;
        got = 0;
        @(negedge i_clk);
        i_a = a;
        i_b = b;
        i_start = 1'b1;
        @(posedge i_clk);
        for (int i = 0; i < W + 6 && !got; i++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (i == inj_at) begin
                i_a = 8'h10;
                i_b = 8'h01;
                i_start = 1'b1;
            end else begin
                i_a = a;
                i_b = b;
            end
            if (i == rst_at) begin
                i_rst_n = 1'b0;
                #1;
                check({tag, "_rst_out"},
                      32'({o_busy, o_d, o_d_valid, o_done, o_borrow, o_diff}), 32'd0);
                @(negedge i_clk);
                i_rst_n = 1'b1;
                return;
            end
            if (o_d_valid && idx < W) begin
                seq[idx] = o_d;
                idx++;
            end
            if (o_done) begin
                got = 1;
                lat = i;
            end
        end
        i_start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check({tag, "_diff"}, 32'(o_diff), 32'(exp_diff));
        check({tag, "_borrow"}, 32'(o_borrow), 32'(exp_borrow));
        check({tag, "_dseq"}, 32'(seq), 32'(exp_diff));
        @(negedge i_clk);
        check({tag, "_done_one_cycle"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int last_done;
        int cyc;
        bit spacing_ok;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_a = '0;
        i_b = '0;
        repeat (3) @(negedge i_clk);
        check("reset_outputs", 32'({o_busy, o_d, o_d_valid, o_done, o_borrow, o_diff}), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, -1, -1, "op5a3c");
        check("dseq_literal", 32'(o_diff), 32'h1E);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, -1, -1, "op0001");
        run_op(8'h80, 8'h80, 8'h00, 1'b0, -1, -1, "op8080");
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0, -1, -1, "opff00");
        run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 2, -1, "ignore_start");
        run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, -1, 3, "midreset");
        check("after_reset_diff", 32'(o_diff), 32'd0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, -1, -1, "op0305");

        // Held start: back-to-back ops, one o_done every W+2 cycles.
        @(negedge i_clk);
        i_a = 8'h21;
        i_b = 8'h43;
        i_start = 1'b1;
        done_cnt = 0;
        last_done = -1;
        spacing_ok = 1;
        for (cyc = 0; cyc < 4 * (W + 2); cyc++) begin
            @(negedge i_clk);
            if (o_done) begin
                if (last_done >= 0 && cyc - last_done != W + 2) spacing_ok = 0;
                last_done = cyc;
                done_cnt++;
            end
        end
        check("held_done_count", 32'(done_cnt), 32'd4);
        check("held_done_spacing", 32'(spacing_ok), 32'd1);
        check("held_diff", 32'(o_diff), 32'hDE);
        check("held_borrow", 32'(o_borrow), 32'd1);

        // Random operands changing every cycle with start held; model checks each op.
        for (int n = 0; n < 300 * (W + 2); n++) begin
            i_a = W'($urandom);
            i_b = W'($urandom);
            @(negedge i_clk);
        end
        i_start = 1'b0;
        repeat (W + 4) @(negedge i_clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
